// File: rtl/sdc_dma_upsizer.sv
// 32-bit INCR-burst DMA port to DATA_W-wide AXI master adapter.
// Write path packs narrow beats into strobed wide beats; read path unpacks wide beats.

module sdc_dma_wlane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] data,
  output logic [3:0]  strb
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      strb <= '0;
    end else if (clear) begin
      data <= '0;
      strb <= '0;
    end else if (load) begin
      data <= din;
      strb <= 4'hF;
    end
  end
endmodule

module sdc_dma_upsizer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  // narrow write
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [7:0]          s_aw_len,
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [31:0]         s_w_data,
  input  logic                s_w_last,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  output logic [1:0]          s_b_resp,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  // narrow read
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [7:0]          s_ar_len,
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  output logic [31:0]         s_r_data,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  // wide write
  output logic [ID_W-1:0]     m_aw_id,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  input  logic [1:0]          m_b_resp,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  // wide read
  output logic [ID_W-1:0]     m_ar_id,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  input  logic                m_r_valid,
  output logic                m_r_ready
);
  localparam int R  = DATA_W / 32;
  localparam int LW = $clog2(R);
  localparam int PW = (LW > 0) ? LW : 1;
  localparam int BW = $clog2(DATA_W / 8);
  localparam logic [PW-1:0] LAST_LANE = PW'(R - 1);
  localparam logic [1:0]    SLVERR    = 2'b10;

  function automatic logic [PW-1:0] lane_of(input logic [ADDR_W-1:0] a);
    return PW'((a >> 2) & ADDR_W'(R - 1));
  endfunction

  function automatic logic [7:0] wide_len(input logic [PW-1:0] l0, input logic [7:0] len);
    logic [9:0] s;
    s = 10'(l0) + 10'(len);
    return 8'(s >> LW);
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(DATA_W / 8 - 1);
  endfunction

  assign m_aw_id    = ID_W'(AXI_ID);
  assign m_ar_id    = ID_W'(AXI_ID);
  assign m_aw_size  = 3'(BW);
  assign m_ar_size  = 3'(BW);
  assign m_aw_burst = 2'b01;
  assign m_ar_burst = 2'b01;

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  w_state_t      w_state;
  logic [PW-1:0] w_ptr;
  logic          w_acc, w_wide_hs;

  assign s_aw_ready = (w_state == W_IDLE);
  assign s_w_ready  = (w_state == W_DATA) && !m_w_valid;
  assign m_b_ready  = (w_state == W_RESP) && !s_b_valid;
  assign w_acc      = s_w_valid && s_w_ready;
  assign w_wide_hs  = m_w_valid && m_w_ready;

  for (genvar i = 0; i < R; i++) begin : g_lane
    sdc_dma_wlane u_lane (
      .clk   (aclk),
      .rst_n (aresetn),
      .load  (w_acc && (w_ptr == PW'(i))),
      .clear (w_wide_hs),
      .din   (s_w_data),
      .data  (m_w_data[32*i +: 32]),
      .strb  (m_w_strb[4*i +: 4])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state    <= W_IDLE;
      w_ptr      <= '0;
      m_aw_addr  <= '0;
      m_aw_len   <= '0;
      m_aw_valid <= 1'b0;
      m_w_valid  <= 1'b0;
      m_w_last   <= 1'b0;
      s_b_valid  <= 1'b0;
      s_b_resp   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s_aw_valid) begin
          m_aw_addr  <= align(s_aw_addr);
          m_aw_len   <= wide_len(lane_of(s_aw_addr), s_aw_len);
          w_ptr      <= lane_of(s_aw_addr);
          m_aw_valid <= 1'b1;
          w_state    <= W_ADDR;
        end
        W_ADDR: if (m_aw_ready) begin
          m_aw_valid <= 1'b0;
          w_state    <= W_DATA;
        end
        W_DATA: begin
          // close the wide beat on the top lane or the burst's final narrow beat
          if (w_acc) begin
            if (w_ptr == LAST_LANE || s_w_last) begin
              m_w_valid <= 1'b1;
              m_w_last  <= s_w_last;
              w_ptr     <= '0;
            end else begin
              w_ptr <= w_ptr + 1'b1;
            end
          end
          if (w_wide_hs) begin
            m_w_valid <= 1'b0;
            m_w_last  <= 1'b0;
            if (m_w_last) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_b_valid && m_b_ready) begin
            s_b_resp  <= m_b_resp;
            s_b_valid <= 1'b1;
          end
          if (s_b_valid && s_b_ready) begin
            s_b_valid <= 1'b0;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  r_state_t          r_state;
  logic [PW-1:0]     r_lane0, r_ptr;
  logic [7:0]        r_len, r_cnt;
  logic              r_first, r_mlast, r_drain;
  logic [DATA_W-1:0] r_buf;
  logic [1:0]        r_resp;
  logic              r_buf_valid;
  logic              r_cap, r_fill, r_nhs, r_done;

  // r_drain swallows surplus wide beats after the narrow burst has completed
  assign m_r_ready  = ((r_state == R_DATA) && !r_buf_valid && !r_mlast) || r_drain;
  assign r_cap      = m_r_valid && m_r_ready && !r_drain && (r_state == R_DATA);
  // wide burst ended early: synthesize SLVERR beats for the rest
  assign r_fill     = (r_state == R_DATA) && r_mlast && !r_buf_valid;
  assign r_done     = (r_cnt == r_len);
  assign s_ar_ready = (r_state == R_IDLE);
  assign s_r_valid  = r_buf_valid || r_fill;
  assign s_r_data   = r_buf_valid ? 32'(r_buf >> {r_ptr, 5'b0}) : 32'h0;
  assign s_r_resp   = r_buf_valid ? r_resp : SLVERR;
  assign s_r_last   = (r_state == R_DATA) && r_done;
  assign r_nhs      = s_r_valid && s_r_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= R_IDLE;
      m_ar_addr   <= '0;
      m_ar_len    <= '0;
      m_ar_valid  <= 1'b0;
      r_lane0     <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_mlast     <= 1'b0;
      r_drain     <= 1'b0;
      r_buf       <= '0;
      r_resp      <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      if (r_drain && m_r_valid && m_r_last) r_drain <= 1'b0;
      case (r_state)
        R_IDLE: if (s_ar_valid) begin
          m_ar_addr  <= align(s_ar_addr);
          m_ar_len   <= wide_len(lane_of(s_ar_addr), s_ar_len);
          m_ar_valid <= 1'b1;
          r_lane0    <= lane_of(s_ar_addr);
          r_len      <= s_ar_len;
          r_cnt      <= '0;
          r_first    <= 1'b1;
          r_mlast    <= 1'b0;
          r_state    <= R_ADDR;
        end
        R_ADDR: if (m_ar_ready) begin
          m_ar_valid <= 1'b0;
          r_state    <= R_DATA;
        end
        R_DATA: begin
          if (r_cap) begin
            r_buf       <= m_r_data;
            r_resp      <= m_r_resp;
            r_buf_valid <= 1'b1;
            r_ptr       <= r_first ? r_lane0 : '0;
            r_first     <= 1'b0;
            if (m_r_last) r_mlast <= 1'b1;
          end
          if (r_nhs) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_ptr == LAST_LANE || r_done) begin
              r_buf_valid <= 1'b0;
              r_ptr       <= '0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
            if (r_done) begin
              r_state <= R_IDLE;
              if (!r_mlast) r_drain <= 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_dma_upsizer.sv
// Directed bench for sdc_dma_upsizer at DATA_W=64: packing, unpacking, errors, stalls, reset.

module tb_sdc_dma_upsizer;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int LIM    = 50;

  logic              aclk, aresetn;
  logic [ADDR_W-1:0] s_aw_addr, s_ar_addr;
  logic [7:0]        s_aw_len, s_ar_len;
  logic              s_aw_valid, s_aw_ready, s_ar_valid, s_ar_ready;
  logic [31:0]       s_w_data, s_r_data;
  logic              s_w_last, s_w_valid, s_w_ready;
  logic [1:0]        s_b_resp, s_r_resp;
  logic              s_b_valid, s_b_ready;
  logic              s_r_last, s_r_valid, s_r_ready;
  logic [ID_W-1:0]   m_aw_id, m_ar_id;
  logic [ADDR_W-1:0] m_aw_addr, m_ar_addr;
  logic [7:0]        m_aw_len, m_ar_len;
  logic [2:0]        m_aw_size, m_ar_size;
  logic [1:0]        m_aw_burst, m_ar_burst;
  logic              m_aw_valid, m_aw_ready, m_ar_valid, m_ar_ready;
  logic [DATA_W-1:0] m_w_data, m_r_data;
  logic [7:0]        m_w_strb;
  logic              m_w_last, m_w_valid, m_w_ready;
  logic [1:0]        m_b_resp, m_r_resp;
  logic              m_b_valid, m_b_ready;
  logic              m_r_last, m_r_valid, m_r_ready;

  int errors = 0;
  int checks = 0;

  sdc_dma_upsizer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_last(s_w_last), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_valid(s_r_valid),
    .s_r_ready(s_r_ready),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
    .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_valid(m_r_valid),
    .m_r_ready(m_r_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_req(input string tag, input logic [31:0] a, input logic [7:0] l,
                        input logic [31:0] ea, input logic [7:0] el);
    int n = 0;
    s_aw_addr = a; s_aw_len = l; s_aw_valid = 1'b1;
    while (s_aw_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_aw_to"}, 64'(n < LIM), 64'd1);
    @(negedge aclk);
    s_aw_valid = 1'b0;
    chk({tag, "_aw_valid"}, 64'(m_aw_valid), 64'd1);
    chk({tag, "_aw_addr"}, 64'(m_aw_addr), 64'(ea));
    chk({tag, "_aw_len"}, 64'(m_aw_len), 64'(el));
    chk({tag, "_aw_sz_bu_id"}, {m_aw_size, m_aw_burst, m_aw_id}, {3'd3, 2'd1, 4'd0});
    m_aw_ready = 1'b1;
    @(negedge aclk);
    m_aw_ready = 1'b0;
    chk({tag, "_aw_drop"}, 64'(m_aw_valid), 64'd0);
  endtask

  task automatic w_beat(input string tag, input logic [31:0] d, input logic l);
    int n = 0;
    s_w_data = d; s_w_last = l; s_w_valid = 1'b1;
    while (s_w_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_w_to"}, 64'(n < LIM), 64'd1);
    @(negedge aclk);
    s_w_valid = 1'b0;
  endtask

  task automatic wide_chk(input string tag, input logic [63:0] ed, input logic [63:0] mask,
                          input logic [7:0] es, input logic el);
    int n = 0;
    while (m_w_valid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_mw_to"}, 64'(n < LIM), 64'd1);
    chk({tag, "_data"}, m_w_data & mask, ed & mask);
    chk({tag, "_strb"}, 64'(m_w_strb), 64'(es));
    chk({tag, "_last"}, 64'(m_w_last), 64'(el));
    m_w_ready = 1'b1;
    @(negedge aclk);
    m_w_ready = 1'b0;
  endtask

  task automatic b_resp(input string tag, input logic [1:0] resp);
    int n = 0;
    while (m_b_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_b_to"}, 64'(n < LIM), 64'd1);
    m_b_valid = 1'b1; m_b_resp = resp;
    @(negedge aclk);
    m_b_valid = 1'b0;
    chk({tag, "_sb_valid"}, 64'(s_b_valid), 64'd1);
    chk({tag, "_sb_resp"}, 64'(s_b_resp), 64'(resp));
    s_b_ready = 1'b1;
    @(negedge aclk);
    s_b_ready = 1'b0;
    chk({tag, "_sb_done"}, {s_b_valid, s_aw_ready}, 64'b01);
  endtask

  task automatic ar_req(input string tag, input logic [31:0] a, input logic [7:0] l,
                        input logic [31:0] ea, input logic [7:0] el);
    int n = 0;
    s_ar_addr = a; s_ar_len = l; s_ar_valid = 1'b1;
    while (s_ar_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_ar_to"}, 64'(n < LIM), 64'd1);
    @(negedge aclk);
    s_ar_valid = 1'b0;
    chk({tag, "_ar_valid"}, 64'(m_ar_valid), 64'd1);
    chk({tag, "_ar_addr"}, 64'(m_ar_addr), 64'(ea));
    chk({tag, "_ar_len"}, 64'(m_ar_len), 64'(el));
    chk({tag, "_ar_sz_bu_id"}, {m_ar_size, m_ar_burst, m_ar_id}, {3'd3, 2'd1, 4'd0});
    m_ar_ready = 1'b1;
    @(negedge aclk);
    m_ar_ready = 1'b0;
  endtask

  task automatic m_r_beat(input string tag, input logic [63:0] d, input logic [1:0] resp,
                          input logic l);
    int n = 0;
    m_r_data = d; m_r_resp = resp; m_r_last = l; m_r_valid = 1'b1;
    while (m_r_ready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_mr_to"}, 64'(n < LIM), 64'd1);
    @(negedge aclk);
    m_r_valid = 1'b0;
  endtask

  task automatic r_narrow(input string tag, input logic [31:0] ed, input logic [1:0] er,
                          input logic el);
    int n = 0;
    while (s_r_valid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
    chk({tag, "_sr_to"}, 64'(n < LIM), 64'd1);
    chk({tag, "_sr_data"}, 64'(s_r_data), 64'(ed));
    chk({tag, "_sr_resp"}, 64'(s_r_resp), 64'(er));
    chk({tag, "_sr_last"}, 64'(s_r_last), 64'(el));
    s_r_ready = 1'b1;
    @(negedge aclk);
    s_r_ready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    s_aw_addr = '0; s_aw_len = '0; s_aw_valid = 1'b0;
    s_w_data = '0; s_w_last = 1'b0; s_w_valid = 1'b0; s_b_ready = 1'b0;
    s_ar_addr = '0; s_ar_len = '0; s_ar_valid = 1'b0; s_r_ready = 1'b0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_resp = '0; m_b_valid = 1'b0;
    m_ar_ready = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0; m_r_valid = 1'b0;
    repeat (3) @(negedge aclk);

    // reset state
    chk("rst_valids", {m_aw_valid, m_ar_valid, m_w_valid, s_b_valid, s_r_valid}, 64'd0);
    chk("rst_readies", {s_w_ready, m_b_ready, m_r_ready}, 64'd0);
    chk("rst_strb", 64'(m_w_strb), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_idle_ready", {s_aw_ready, s_ar_ready}, 64'b11);

    // aligned 64b write, 4 narrow beats -> 2 wide
    aw_req("w1", 32'h1000, 8'd3, 32'h1000, 8'd1);
    chk("w1_sw_ready", 64'(s_w_ready), 64'd1);
    w_beat("w1", 32'd1, 1'b0);
    w_beat("w1", 32'd2, 1'b0);
    wide_chk("w1_b0", 64'h00000002_00000001, '1, 8'hFF, 1'b0);
    chk("w1_mw_drop", 64'(m_w_valid), 64'd0);
    w_beat("w1", 32'd3, 1'b0);
    w_beat("w1", 32'd4, 1'b1);
    wide_chk("w1_b1", 64'h00000004_00000003, '1, 8'hFF, 1'b1);
    b_resp("w1", 2'b00);

    // unaligned start on lane 1, SLVERR response
    aw_req("w2", 32'h1004, 8'd2, 32'h1000, 8'd1);
    w_beat("w2", 32'h0000_00A1, 1'b0);
    wide_chk("w2_b0", 64'h000000A1_00000000, 64'hFFFFFFFF_00000000, 8'hF0, 1'b0);
    w_beat("w2", 32'h0000_00B2, 1'b0);
    w_beat("w2", 32'h0000_00C3, 1'b1);
    wide_chk("w2_b1", 64'h000000C3_000000B2, '1, 8'hFF, 1'b1);
    b_resp("w2", 2'b10);

    // wide-side backpressure mid-burst
    aw_req("w3", 32'h2000, 8'd5, 32'h2000, 8'd2);
    w_beat("w3", 32'd1, 1'b0);
    w_beat("w3", 32'd2, 1'b0);
    s_w_data = 32'd3; s_w_last = 1'b0; s_w_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("w3_stall_ready", {s_w_ready, m_w_valid}, 64'b01);
    end
    chk("w3_stall_data", m_w_data, 64'h00000002_00000001);
    m_w_ready = 1'b1;
    @(negedge aclk);
    m_w_ready = 1'b0;
    chk("w3_release", {m_w_valid, s_w_ready}, 64'b01);
    w_beat("w3", 32'd3, 1'b0);
    w_beat("w3", 32'd4, 1'b0);
    wide_chk("w3_b1", 64'h00000004_00000003, '1, 8'hFF, 1'b0);
    w_beat("w3", 32'd5, 1'b0);
    w_beat("w3", 32'd6, 1'b1);
    wide_chk("w3_b2", 64'h00000006_00000005, '1, 8'hFF, 1'b1);
    b_resp("w3", 2'b00);

    // single-beat read from lane 1
    ar_req("r1", 32'h1004, 8'd0, 32'h1000, 8'd0);
    chk("r1_mr_ready", 64'(m_r_ready), 64'd1);
    m_r_beat("r1", 64'hAAAABBBB_CCCCDDDD, 2'b00, 1'b1);
    chk("r1_hold", 64'(m_r_ready), 64'd0);
    r_narrow("r1", 32'hAAAABBBB, 2'b00, 1'b1);
    chk("r1_idle", {s_ar_ready, s_r_valid}, 64'b10);

    // multi-beat read, SLVERR on first wide beat only
    ar_req("r2", 32'h3000, 8'd2, 32'h3000, 8'd1);
    m_r_beat("r2a", 64'h22222222_11111111, 2'b10, 1'b0);
    r_narrow("r2a0", 32'h11111111, 2'b10, 1'b0);
    r_narrow("r2a1", 32'h22222222, 2'b10, 1'b0);
    m_r_beat("r2b", 64'h44444444_33333333, 2'b00, 1'b1);
    r_narrow("r2b0", 32'h33333333, 2'b00, 1'b1);
    chk("r2_idle", 64'(s_ar_ready), 64'd1);

    // wide burst ends early: trailing narrow beats are SLVERR with zero data
    ar_req("r3", 32'h4000, 8'd3, 32'h4000, 8'd1);
    m_r_beat("r3", 64'h66666666_55555555, 2'b00, 1'b1);
    r_narrow("r3_0", 32'h55555555, 2'b00, 1'b0);
    r_narrow("r3_1", 32'h66666666, 2'b00, 1'b0);
    r_narrow("r3_2", 32'h0, 2'b10, 1'b0);
    r_narrow("r3_3", 32'h0, 2'b10, 1'b1);
    chk("r3_idle", 64'(s_ar_ready), 64'd1);

    // surplus wide beat after narrow completion is accepted and dropped
    ar_req("r4", 32'h5000, 8'd0, 32'h5000, 8'd0);
    m_r_beat("r4a", 64'h77777777_12345678, 2'b00, 1'b0);
    r_narrow("r4", 32'h12345678, 2'b00, 1'b1);
    chk("r4_drain_ready", 64'(m_r_ready), 64'd1);
    m_r_beat("r4b", 64'h99999999_88888888, 2'b00, 1'b1);
    chk("r4_drained", {m_r_ready, s_r_valid, s_ar_ready}, 64'b001);

    // reset while a read beat is buffered
    ar_req("r5", 32'h6000, 8'd1, 32'h6000, 8'd0);
    m_r_beat("r5", 64'hDEADBEEF_CAFEF00D, 2'b00, 1'b1);
    chk("r5_full", 64'(s_r_valid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("r5_async_valids", {m_aw_valid, m_ar_valid, m_w_valid, s_b_valid, s_r_valid}, 64'd0);
    chk("r5_async_ready", 64'(m_r_ready), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("r5_post_release", {s_ar_ready, s_aw_ready, s_r_valid, m_r_ready}, 64'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
